t04_mem_arbiter: RTL and testbench
==================================

T04_MEM_ARBITER -- requirements
Module: t04_mem_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255: bus-ack wait limit in cycles (1..255), used only when T04_ARB_TIMEOUT_EN is defined.
REQ-002 SHALL have ports: clk  in  1  system clock, rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-low.
REQ-004 i_req  in  1  fetch request, held until i_ack.
REQ-005 i_addr  in  32  fetch address.
REQ-006 d_read  in  1  data load request, held until d_ack.
REQ-007 d_write  in  1  data store request, held until d_ack.
REQ-008 d_addr  in  32  data address; d_wdata  in  32  store data; d_sel  in  4  byte enables.
REQ-009 i_ack  out  1  one-cycle fetch-complete pulse; instruction  out  32  fetched word.
REQ-010 d_ack  out  1  one-cycle data-complete pulse; memload  out  32  loaded word.
REQ-011 bus_read, bus_write  out  1 each  shared-bus strobes.
REQ-012 bus_addr  out  32; bus_wdata  out  32; bus_sel  out  4  shared-bus request fields.
REQ-013 bus_rdata  in  32  bus read data; bus_ack  in  1  bus completion, one cycle.
REQ-014 busy  out  1  high in any state other than IDLE; arb_err  out  1  sticky timeout flag.

Function
REQ-015 SHALL implement FSM states IDLE, FETCH, DATA, RESP.
REQ-016 IDLE: with only a data request (d_read|d_write) pending, SHALL move to DATA; with only i_req pending, SHALL move to FETCH; with none, SHALL stay.
REQ-017 IDLE with both pending SHALL grant the requester not granted last (round-robin); after reset, data wins the first tie.
REQ-018 On grant, SHALL register the address, wdata, sel and direction; bus outputs SHALL be driven from these registers from the next cycle and held stable until bus_ack.
REQ-019 d_read and d_write both high SHALL be treated as a write.
REQ-020 FETCH: bus_read=1, bus_write=0, bus_sel=4'hF.
REQ-021 DATA: bus_read or bus_write asserted per the latched direction, never both.
REQ-022 On bus_ack in FETCH or DATA, SHALL capture bus_rdata into instruction (FETCH) or memload (DATA load), drop the strobes, and enter RESP.
REQ-023 On a store, memload SHALL keep its previous value.
REQ-024 RESP SHALL last exactly one cycle, pulse i_ack or d_ack for the served requester, ignore all requests, and return to IDLE.
REQ-025 Minimum latency: request seen at edge N -> strobe in cycle N+1; bus_ack at edge M -> ack high in cycle M+1.
REQ-026 instruction and memload SHALL hold their values until the next capture.
REQ-027 bus_ack while in IDLE or RESP SHALL be ignored.
REQ-028 Request inputs changing during FETCH or DATA SHALL NOT alter the bus outputs.

Reset
REQ-029 rst low SHALL immediately force state IDLE and all outputs to 0, including instruction, memload and arb_err, and set the round-robin pointer to "data next"; an in-flight transaction is abandoned with no ack.
REQ-030 After rst rises, the first grant decision SHALL occur at the first rising clk edge.

Configuration
REQ-031 With macro T04_ARB_TIMEOUT_EN defined: an 8-bit counter SHALL clear on entry to FETCH or DATA and increment each cycle without bus_ack.
REQ-032 Under the macro, on reaching TIMEOUT_CYCLES the arbiter SHALL drop the strobes, set arb_err=1 until reset, load 32'hDEADBEEF into instruction or memload for the served port, and enter RESP.
REQ-033 Without the macro: no counter, arb_err tied to 0, FETCH/DATA wait indefinitely.

Verification
REQ-034 i_req=1, i_addr=0x100, bus_ack 3 cycles after bus_read with bus_rdata=0x00500093 -> bus_addr=0x100; one i_ack pulse with instruction=0x00500093; d_ack stays 0.
REQ-035 i_req and d_read both high from reset, d_addr=0x2000 -> DATA served first, then FETCH; the next tie goes to the other requester.
REQ-036 d_write=1, d_addr=0x3004, d_wdata=0xCAFEF00D, d_sel=4'b0011 -> bus_write=1 with these fields stable until bus_ack; d_ack pulses; memload unchanged.
REQ-037 rst pulled low mid-DATA before bus_ack -> all outputs 0 asynchronously, no d_ack; after release, a new i_req is granted normally.
REQ-038 T04_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=4, i_req with no bus_ack -> strobes drop after 4 cycles; i_ack pulses with instruction=0xDEADBEEF; arb_err=1 until reset.
REQ-039 d_read and d_write both high -> bus_write=1, bus_read=0.

Source files
------------

// File: rtl/t04_mem_arbiter.sv
// rtl/t04_mem_arbiter.sv - fetch/data round-robin arbiter onto one shared memory bus; optional ack timeout under T04_ARB_TIMEOUT_EN
module t04_mem_arbiter #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    input  logic        d_read,
    input  logic        d_write,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_sel,
    output logic        i_ack,
    output logic [31:0] instruction,
    output logic        d_ack,
    output logic [31:0] memload,
    output logic        bus_read,
    output logic        bus_write,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_sel,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack,
    output logic        busy,
    output logic        arb_err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DATA  = 2'd2,
        S_RESP  = 2'd3
    } state_e;

    state_e      state_q;
    logic        rr_data_next_q;
    logic        i_ack_q;
    logic        d_ack_q;
    logic [31:0] instruction_q;
    logic [31:0] memload_q;
    logic        bus_read_q;
    logic        bus_write_q;
    logic [31:0] bus_addr_q;
    logic [31:0] bus_wdata_q;
    logic [3:0]  bus_sel_q;

    logic        d_pend;
    logic        grant_data_d;
    logic        grant_fetch_d;

`ifdef T04_ARB_TIMEOUT_EN
    logic [7:0]  tmo_cnt_q;
    logic        arb_err_q;
    logic        tmo_hit;

    // Timeout fires on the edge that would complete the TIMEOUT_CYCLES-th strobe cycle
    assign tmo_hit = (tmo_cnt_q == 8'(TIMEOUT_CYCLES - 1));
    assign arb_err = arb_err_q;
`else
    logic [7:0]  unused_timeout;

    assign unused_timeout = 8'(TIMEOUT_CYCLES);
    assign arb_err        = 1'b0;
`endif

    // Grant decision in IDLE: a lone requester wins, a tie goes to the side not served last
    always_comb begin
        grant_data_d  = 1'b0;
        grant_fetch_d = 1'b0;
        d_pend        = d_read | d_write;
        if (d_pend && i_req) begin
            grant_data_d  = rr_data_next_q;
            grant_fetch_d = ~rr_data_next_q;
        end else if (d_pend) begin
            grant_data_d  = 1'b1;
        end else if (i_req) begin
            grant_fetch_d = 1'b1;
        end
    end

    // Arbiter FSM: latches the granted request onto the bus registers and returns one ack pulse
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= S_IDLE;
            rr_data_next_q <= 1'b1;
            i_ack_q        <= 1'b0;
            d_ack_q        <= 1'b0;
            instruction_q  <= '0;
            memload_q      <= '0;
            bus_read_q     <= 1'b0;
            bus_write_q    <= 1'b0;
            bus_addr_q     <= '0;
            bus_wdata_q    <= '0;
            bus_sel_q      <= '0;
`ifdef T04_ARB_TIMEOUT_EN
            tmo_cnt_q      <= '0;
            arb_err_q      <= 1'b0;
`endif
        end else begin
            i_ack_q <= 1'b0;
            d_ack_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
`ifdef T04_ARB_TIMEOUT_EN
                    tmo_cnt_q <= '0;
`endif
                    if (grant_data_d) begin
                        state_q        <= S_DATA;
                        rr_data_next_q <= 1'b0;
                        bus_addr_q     <= d_addr;
                        bus_wdata_q    <= d_wdata;
                        bus_sel_q      <= d_sel;
                        // A simultaneous read+write is a store
                        bus_write_q    <= d_write;
                        bus_read_q     <= ~d_write;
                    end else if (grant_fetch_d) begin
                        state_q        <= S_FETCH;
                        rr_data_next_q <= 1'b1;
                        bus_addr_q     <= i_addr;
                        bus_wdata_q    <= '0;
                        bus_sel_q      <= 4'hF;
                        bus_write_q    <= 1'b0;
                        bus_read_q     <= 1'b1;
                    end
                end
                S_FETCH, S_DATA: begin
                    if (bus_ack) begin
                        state_q     <= S_RESP;
                        bus_read_q  <= 1'b0;
                        bus_write_q <= 1'b0;
                        if (state_q == S_DATA) begin
                            d_ack_q <= 1'b1;
                            // Stores leave the last loaded word in place
                            if (!bus_write_q) begin
                                memload_q <= bus_rdata;
                            end
                        end else begin
                            i_ack_q       <= 1'b1;
                            instruction_q <= bus_rdata;
                        end
                    end
`ifdef T04_ARB_TIMEOUT_EN
                    else if (tmo_hit) begin
                        state_q     <= S_RESP;
                        bus_read_q  <= 1'b0;
                        bus_write_q <= 1'b0;
                        arb_err_q   <= 1'b1;
                        if (state_q == S_DATA) begin
                            d_ack_q   <= 1'b1;
                            memload_q <= 32'hDEADBEEF;
                        end else begin
                            i_ack_q       <= 1'b1;
                            instruction_q <= 32'hDEADBEEF;
                        end
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + 8'd1;
                    end
`endif
                end
                S_RESP: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign i_ack       = i_ack_q;
    assign d_ack       = d_ack_q;
    assign instruction = instruction_q;
    assign memload     = memload_q;
    assign bus_read    = bus_read_q;
    assign bus_write   = bus_write_q;
    assign bus_addr    = bus_addr_q;
    assign bus_wdata   = bus_wdata_q;
    assign bus_sel     = bus_sel_q;
    assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_t04_mem_arbiter.sv
// tb/tb_t04_mem_arbiter.sv - directed self-checking bench for t04_mem_arbiter
module tb_t04_mem_arbiter;

`ifdef T04_ARB_TIMEOUT_EN
    localparam int TMO = 4;
`else
    localparam int TMO = 255;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req;
    logic [31:0] i_addr;
    logic        d_read;
    logic        d_write;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_sel;
    logic        i_ack;
    logic [31:0] instruction;
    logic        d_ack;
    logic [31:0] memload;
    logic        bus_read;
    logic        bus_write;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_sel;
    logic [31:0] bus_rdata;
    logic        bus_ack;
    logic        busy;
    logic        arb_err;

    int vectors     = 0;
    int miscompares = 0;

    t04_mem_arbiter #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr),
        .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata), .d_sel(d_sel),
        .i_ack(i_ack), .instruction(instruction), .d_ack(d_ack), .memload(memload),
        .bus_read(bus_read), .bus_write(bus_write), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_sel(bus_sel), .bus_rdata(bus_rdata), .bus_ack(bus_ack), .busy(busy), .arb_err(arb_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1;
        vectors++;
        if ({i_ack, d_ack, bus_read, bus_write, busy, arb_err, bus_sel} !== 10'b0) begin
            miscompares++;
            $display("FAIL reset_ctrl: got %b expected 0", {i_ack, d_ack, bus_read, bus_write, busy, arb_err, bus_sel});
        end
        vectors++;
        if ({instruction, memload, bus_addr, bus_wdata} !== 128'b0) begin
            miscompares++;
            $display("FAIL reset_data: got %h expected 0", {instruction, memload, bus_addr, bus_wdata});
        end
        step();
        step();
        rst = 1'b1;
    endtask

    task automatic test_fetch();
        i_req  = 1'b1;
        i_addr = 32'h100;
        step();
        vectors++;
        if ({bus_read, bus_write, bus_sel, busy} !== {1'b1, 1'b0, 4'hF, 1'b1}) begin
            miscompares++;
            $display("FAIL fetch_strobe: got %b expected 1011111", {bus_read, bus_write, bus_sel, busy});
        end
        vectors++;
        if (bus_addr !== 32'h100) begin
            miscompares++;
            $display("FAIL fetch_addr: got %h expected 00000100", bus_addr);
        end
        i_addr = 32'hFFF0;
        for (int k = 0; k < 2; k++) begin
            step();
            vectors++;
            if ({bus_read, bus_addr, i_ack} !== {1'b1, 32'h100, 1'b0}) begin
                miscompares++;
                $display("FAIL fetch_hold: got %h expected %h", {bus_read, bus_addr, i_ack}, {1'b1, 32'h100, 1'b0});
            end
        end
        bus_ack   = 1'b1;
        bus_rdata = 32'h00500093;
        step();
        bus_ack = 1'b0;
        vectors++;
        if ({i_ack, d_ack, bus_read} !== 3'b100) begin
            miscompares++;
            $display("FAIL fetch_ack: got %b expected 100", {i_ack, d_ack, bus_read});
        end
        vectors++;
        if (instruction !== 32'h00500093) begin
            miscompares++;
            $display("FAIL fetch_insn: got %h expected 00500093", instruction);
        end
        i_req = 1'b0;
        step();
        vectors++;
        if ({i_ack, d_ack, busy} !== 3'b000) begin
            miscompares++;
            $display("FAIL fetch_done: got %b expected 000", {i_ack, d_ack, busy});
        end
    endtask

    task automatic test_idle_ack();
        bus_ack   = 1'b1;
        bus_rdata = 32'hBAD0BAD0;
        step();
        bus_ack = 1'b0;
        vectors++;
        if ({i_ack, d_ack, busy, instruction} !== {3'b000, 32'h00500093}) begin
            miscompares++;
            $display("FAIL idle_ack: got %h expected %h", {i_ack, d_ack, busy, instruction}, {3'b000, 32'h00500093});
        end
    endtask

    task automatic test_tie();
        logic        exp_data [3];
        logic [31:0] exp_addr [3];
        logic [31:0] rd       [3];
        exp_data = '{1'b1, 1'b0, 1'b1};
        exp_addr = '{32'h2000, 32'h400, 32'h2000};
        rd       = '{32'hAAAA0001, 32'hBBBB0002, 32'hAAAA0003};
        rst = 1'b0;
        #2;
        rst    = 1'b1;
        i_req  = 1'b1;
        i_addr = 32'h400;
        d_read = 1'b1;
        d_addr = 32'h2000;
        for (int i = 0; i < 3; i++) begin
            step();
            vectors++;
            if ({bus_read, bus_write, bus_addr} !== {2'b10, exp_addr[i]}) begin
                miscompares++;
                $display("FAIL tie_grant[%0d]: got %h expected %h", i, {bus_read, bus_write, bus_addr}, {2'b10, exp_addr[i]});
            end
            bus_ack   = 1'b1;
            bus_rdata = rd[i];
            step();
            bus_ack = 1'b0;
            vectors++;
            if ({i_ack, d_ack} !== {~exp_data[i], exp_data[i]}) begin
                miscompares++;
                $display("FAIL tie_ack[%0d]: got %b expected %b", i, {i_ack, d_ack}, {~exp_data[i], exp_data[i]});
            end
            vectors++;
            if ((exp_data[i] ? memload : instruction) !== rd[i]) begin
                miscompares++;
                $display("FAIL tie_capture[%0d]: got %h expected %h", i, (exp_data[i] ? memload : instruction), rd[i]);
            end
            step();
            vectors++;
            if (busy !== 1'b0) begin
                miscompares++;
                $display("FAIL tie_idle[%0d]: got %b expected 0", i, busy);
            end
        end
        i_req  = 1'b0;
        d_read = 1'b0;
    endtask

    task automatic test_store();
        d_write = 1'b1;
        d_addr  = 32'h3004;
        d_wdata = 32'hCAFEF00D;
        d_sel   = 4'b0011;
        step();
        vectors++;
        if ({bus_read, bus_write, bus_addr, bus_wdata, bus_sel} !== {2'b01, 32'h3004, 32'hCAFEF00D, 4'b0011}) begin
            miscompares++;
            $display("FAIL store_fields: got %h expected %h", {bus_read, bus_write, bus_addr, bus_wdata, bus_sel},
                     {2'b01, 32'h3004, 32'hCAFEF00D, 4'b0011});
        end
        d_addr  = 32'h0;
        d_wdata = 32'h0;
        d_sel   = 4'hF;
        for (int k = 0; k < 2; k++) begin
            step();
            vectors++;
            if ({bus_write, bus_addr, bus_wdata, bus_sel} !== {1'b1, 32'h3004, 32'hCAFEF00D, 4'b0011}) begin
                miscompares++;
                $display("FAIL store_hold: got %h expected %h", {bus_write, bus_addr, bus_wdata, bus_sel},
                         {1'b1, 32'h3004, 32'hCAFEF00D, 4'b0011});
            end
        end
        bus_ack   = 1'b1;
        bus_rdata = 32'h12345678;
        step();
        bus_ack = 1'b0;
        vectors++;
        if ({d_ack, i_ack, bus_write, memload} !== {3'b100, 32'hAAAA0003}) begin
            miscompares++;
            $display("FAIL store_ack: got %h expected %h", {d_ack, i_ack, bus_write, memload}, {3'b100, 32'hAAAA0003});
        end
        d_write = 1'b0;
        step();
    endtask

    task automatic test_rw_both();
        d_read  = 1'b1;
        d_write = 1'b1;
        d_addr  = 32'h3010;
        step();
        vectors++;
        if ({bus_read, bus_write} !== 2'b01) begin
            miscompares++;
            $display("FAIL rw_both: got %b expected 01", {bus_read, bus_write});
        end
        bus_ack   = 1'b1;
        bus_rdata = 32'h55555555;
        step();
        bus_ack = 1'b0;
        vectors++;
        if ({d_ack, memload} !== {1'b1, 32'hAAAA0003}) begin
            miscompares++;
            $display("FAIL rw_both_ack: got %h expected %h", {d_ack, memload}, {1'b1, 32'hAAAA0003});
        end
        d_read  = 1'b0;
        d_write = 1'b0;
        step();
    endtask

    task automatic test_reset_mid();
        d_read = 1'b1;
        d_addr = 32'h5000;
        step();
        vectors++;
        if ({bus_read, bus_addr} !== {1'b1, 32'h5000}) begin
            miscompares++;
            $display("FAIL mid_grant: got %h expected %h", {bus_read, bus_addr}, {1'b1, 32'h5000});
        end
        #2;
        rst = 1'b0;
        #1;
        vectors++;
        if ({bus_read, bus_write, busy, d_ack, i_ack, bus_addr, instruction, memload} !== 101'b0) begin
            miscompares++;
            $display("FAIL mid_async_reset: got %h expected 0", {bus_read, bus_write, busy, d_ack, i_ack, bus_addr, instruction, memload});
        end
        d_read = 1'b0;
        #1;
        rst       = 1'b1;
        bus_ack   = 1'b1;
        bus_rdata = 32'h77777777;
        step();
        bus_ack = 1'b0;
        vectors++;
        if ({d_ack, i_ack, busy, memload} !== 35'b0) begin
            miscompares++;
            $display("FAIL mid_no_ack: got %h expected 0", {d_ack, i_ack, busy, memload});
        end
        i_req  = 1'b1;
        i_addr = 32'h600;
        step();
        vectors++;
        if ({bus_read, bus_addr} !== {1'b1, 32'h600}) begin
            miscompares++;
            $display("FAIL post_reset_grant: got %h expected %h", {bus_read, bus_addr}, {1'b1, 32'h600});
        end
        bus_ack   = 1'b1;
        bus_rdata = 32'h00000013;
        step();
        bus_ack = 1'b0;
        vectors++;
        if ({i_ack, instruction} !== {1'b1, 32'h00000013}) begin
            miscompares++;
            $display("FAIL post_reset_ack: got %h expected %h", {i_ack, instruction}, {1'b1, 32'h00000013});
        end
        i_req = 1'b0;
        step();
        vectors++;
        if (arb_err !== 1'b0) begin
            miscompares++;
            $display("FAIL arb_err_clear: got %b expected 0", arb_err);
        end
    endtask

`ifdef T04_ARB_TIMEOUT_EN
    task automatic test_timeout();
        i_req  = 1'b1;
        i_addr = 32'h700;
        for (int k = 0; k < 4; k++) begin
            step();
            vectors++;
            if ({bus_read, i_ack} !== 2'b10) begin
                miscompares++;
                $display("FAIL tmo_wait[%0d]: got %b expected 10", k, {bus_read, i_ack});
            end
        end
        step();
        vectors++;
        if ({bus_read, i_ack, arb_err, instruction} !== {3'b011, 32'hDEADBEEF}) begin
            miscompares++;
            $display("FAIL tmo_fire: got %h expected %h", {bus_read, i_ack, arb_err, instruction}, {3'b011, 32'hDEADBEEF});
        end
        i_req = 1'b0;
        step();
        step();
        vectors++;
        if ({arb_err, busy} !== 2'b10) begin
            miscompares++;
            $display("FAIL tmo_sticky: got %b expected 10", {arb_err, busy});
        end
        rst = 1'b0;
        #1;
        vectors++;
        if (arb_err !== 1'b0) begin
            miscompares++;
            $display("FAIL tmo_reset: got %b expected 0", arb_err);
        end
        rst = 1'b1;
    endtask
`endif

    initial begin
        rst       = 1'b1;
        i_req     = 1'b0;
        i_addr    = '0;
        d_read    = 1'b0;
        d_write   = 1'b0;
        d_addr    = '0;
        d_wdata   = '0;
        d_sel     = '0;
        bus_rdata = '0;
        bus_ack   = 1'b0;
        #1;
        rst = 1'b0;
        test_reset();
        test_fetch();
        test_idle_ack();
        test_tie();
        test_store();
        test_rw_both();
        test_reset_mid();
`ifdef T04_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
